load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits between the CPU datapath's memory stage and the word-only data memory port of the Harvard CPU.
- Turns one CPU load/store request into word-aligned memory reads and writes.
- Extracts and extends sub-word load data; merges LWL/LWR results.
- Performs read-modify-write for byte and halfword stores, because the memory bus has no byte enables.
- Memory bus: combinational read, single-cycle write, little-endian byte lanes (offset 0 = bits [7:0]).

Parameters:
ADDR_WIDTH, 32, byte address width on both sides.
MEM_WAIT_CYCLES, 0, extra cycles each memory access is held stable before it completes (0 to 15).

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
start  input  1  request strobe; accepted only when busy=0
op  input  4  0000 LB, 0001 LBU, 0010 LH, 0011 LHU, 0100 LW, 0101 LWL, 0110 LWR, 1000 SB, 1001 SH, 1010 SW; others reserved
addr  input  ADDR_WIDTH  byte address
wdata  input  32  store data (rt)
rt_old  input  32  current rt value, used by LWL/LWR merge
busy  output  1  high from the cycle after accept until the cycle DONE is left
done  output  1  one-cycle completion pulse
rdata  output  32  load result; valid with done; held until the next accept
error  output  1  valid with done (see Optional Feature)
mem_address  output  ADDR_WIDTH  word address; addr with bits [1:0] forced to 00
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_writedata  output  32  memory write data
mem_readdata  input  32  combinational memory read data

Behaviour:
- States: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- On reset, go to IDLE and clear all outputs. busy, done, rdata, error, mem_read, mem_write, mem_writedata and mem_address are 0 on the cycle after reset is sampled.
- Reset mid-operation aborts the operation. No memory write is issued after the reset cycle.
- IDLE + start:
  - Latch op, addr, wdata, rt_old; k = addr[1:0].
  - Loads go to RD; SW goes to WR; SB/SH go to RMW_RD.
  - Reserved op goes to DONE with error=1 and no memory access.
- start while busy=1 is ignored. start in the same cycle as DONE is also ignored, because the unit is not back in IDLE yet.
- RD / RMW_RD:
  - mem_read=1; mem_address stable.
  - A wait counter holds the state for MEM_WAIT_CYCLES extra cycles.
  - mem_readdata is captured on the last cycle of the state.
  - Next state: RD goes to DONE; RMW_RD goes to RMW_WR.
- WR / RMW_WR: mem_write=1 with mem_writedata stable for 1+MEM_WAIT_CYCLES cycles, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy=0 in IDLE.
- Latency from the start cycle to the done cycle: loads and SW are 2+MEM_WAIT_CYCLES; SB/SH are 3+2*MEM_WAIT_CYCLES.
- Load data, with word W captured and k = addr[1:0]:
  - LB/LBU: byte W[8k+7:8k], sign- or zero-extended to 32 bits.
  - LH/LHU: halfword W[16h+15:16h] with h = addr[1], sign- or zero-extended.
  - LW: W.
  - LWL: (W << 8*(3-k)) OR (rt_old AND low-(3-k)-byte mask). k=3 gives W.
  - LWR: (W >> 8*k) OR (rt_old AND high-k-byte mask). k=0 gives W.
- Store data:
  - SW writes wdata.
  - SB replaces byte lane k of the read word with wdata[7:0].
  - SH replaces halfword lane addr[1] with wdata[15:0].
  - Lanes not being replaced are unchanged.
- mem_read and mem_write are never high together. Both are 0 in IDLE and DONE.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00, goes straight from accept to DONE with error=1.
  - No memory access is made; rdata is unchanged; latency is 1 cycle.
  - LWL/LWR are never misaligned.
- Undefined:
  - Low address bits beyond the access size are ignored: LH uses addr[1], LW uses the word.
  - error=1 only for reserved ops.

Test Plan:
1. Memory word 0x100 = 0x8899AABB; LB addr 0x103 → mem_read at 0x100, done on cycle 2, rdata=0xFFFFFF88, error=0.
2. Same memory; LHU 0x102 → rdata=0x00008899. LH 0x100 → rdata=0xFFFFAABB.
3. SB 0x101, wdata=0x12345655 → RMW_RD at 0x100, then mem_write data 0x889955BB, done on cycle 3. SH 0x102, wdata=0x0000CAFE → write 0xCAFEAABB.
4. LWL 0x101, rt_old=0x11223344 → rdata=0xAABB3344. LWR 0x101, rt_old=0x11223344 → rdata=0x118899AA.
5. MEM_WAIT_CYCLES=2: LW 0x100 → mem_read held 3 cycles, done on cycle 4. A start during busy is ignored, with no second access.
6. Misaligned LW 0x102:
   - With LSU_MISALIGN_TRAP_EN: done on cycle 1, error=1, no mem_read.
   - Without it: rdata=0x8899AABB.
   Reset during RMW_RD of an SB: no mem_write ever issued; all outputs 0 the next cycle.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundles the CPU-side request/response and the word-only memory port of the LSU.
// The LSU takes the slave view; the CPU datapath plus memory model take the master view.
// The memory read data is combinational, so the master drives it from mem_address.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  start;
  logic [3:0]            op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rt_old;
  logic                  busy;
  logic                  done;
  logic [31:0]           rdata;
  logic                  error;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           mem_writedata;
  logic [31:0]           mem_readdata;

  modport master (
    output start, op, addr, wdata, rt_old, mem_readdata,
    input  busy, done, rdata, error, mem_address, mem_read, mem_write, mem_writedata
  );

  modport slave (
    input  start, op, addr, wdata, rt_old, mem_readdata,
    output busy, done, rdata, error, mem_address, mem_read, mem_write, mem_writedata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: maps CPU byte/half/word/LWL/LWR accesses onto a word-only memory port.
// Latency: loads/SW 2+MEM_WAIT_CYCLES, SB/SH 3+2*MEM_WAIT_CYCLES (read-modify-write), errors 1.
// Backpressure: one request at a time; start is ignored while busy (including the DONE cycle).
// Optional build macro LSU_MISALIGN_TRAP_EN: trap misaligned LH/LHU/SH/LW/SW with error=1.
module load_store_unit #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE} state_t;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LBU = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LHU = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_LWL = 4'b0101;
  localparam logic [3:0] OP_LWR = 4'b0110;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_CYCLES);

  state_t                state, state_d;
  logic [3:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           rt_q;
  logic [31:0]           wr_word;
  logic [31:0]           rdata_q;
  logic                  error_q;
  logic [3:0]            wait_cnt;

  logic                  in_is_load;
  logic                  in_is_rmw;
  logic                  in_is_sw;
  logic                  in_reserved;
  logic                  in_misaligned;
  logic                  last;
  logic [1:0]            k;
  logic [31:0]           load_result;
  logic [31:0]           store_merge;

  assign in_is_load  = (bus.op <= OP_LWR);
  assign in_is_rmw   = (bus.op == OP_SB) || (bus.op == OP_SH);
  assign in_is_sw    = (bus.op == OP_SW);
  assign in_reserved = !(in_is_load || in_is_rmw || in_is_sw);

`ifdef LSU_MISALIGN_TRAP_EN
  assign in_misaligned =
      (((bus.op == OP_LH) || (bus.op == OP_LHU) || (bus.op == OP_SH)) && bus.addr[0]) ||
      (((bus.op == OP_LW) || (bus.op == OP_SW)) && (bus.addr[1:0] != 2'b00));
`else
  assign in_misaligned = 1'b0;
`endif

  // The current access has been held for its full 1+MEM_WAIT_CYCLES cycles.
  assign last = (wait_cnt == WAIT_LAST);
  assign k    = addr_q[1:0];

  // Next-state logic; accepts a request only from IDLE.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (in_reserved || in_misaligned) state_d = DONE;
          else if (in_is_load)               state_d = RD;
          else if (in_is_sw)                 state_d = WR;
          else                               state_d = RMW_RD;
        end
      end
      RD:     if (last) state_d = DONE;
      RMW_RD: if (last) state_d = RMW_WR;
      WR:     if (last) state_d = DONE;
      RMW_WR: if (last) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load data extraction, sign/zero extension and LWL/LWR merge from the read word.
  always_comb begin
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] all_ones;
    all_ones    = '1;
    byte_v      = 8'(bus.mem_readdata >> {k, 3'b000});
    half_v      = k[1] ? bus.mem_readdata[31:16] : bus.mem_readdata[15:0];
    load_result = bus.mem_readdata;
    case (op_q)
      OP_LB:  load_result = {{24{byte_v[7]}}, byte_v};
      OP_LBU: load_result = {24'h0, byte_v};
      OP_LH:  load_result = {{16{half_v[15]}}, half_v};
      OP_LHU: load_result = {16'h0, half_v};
      OP_LW:  load_result = bus.mem_readdata;
      OP_LWL: load_result = (bus.mem_readdata << {~k, 3'b000}) |
                            (rt_q & ~(all_ones << {~k, 3'b000}));
      OP_LWR: load_result = (bus.mem_readdata >> {k, 3'b000}) |
                            (rt_q & ~(all_ones >> {k, 3'b000}));
      default: load_result = bus.mem_readdata;
    endcase
  end

  // Byte/halfword lane replacement into the word read during RMW_RD.
  always_comb begin
    store_merge = bus.mem_readdata;
    if (op_q == OP_SB) store_merge[{k, 3'b000} +: 8] = wr_word[7:0];
    else               store_merge[{k[1], 4'b0000} +: 16] = wr_word[15:0];
  end

  // State, wait counter, request latches and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      rt_q     <= '0;
      wr_word  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= (state_d != state) ? 4'd0 : wait_cnt + 4'd1;
      if (state == IDLE && bus.start) begin
        op_q    <= bus.op;
        addr_q  <= bus.addr;
        rt_q    <= bus.rt_old;
        wr_word <= bus.wdata;
        error_q <= in_reserved || in_misaligned;
      end
      if (state == RD && last)     rdata_q <= load_result;
      if (state == RMW_RD && last) wr_word <= store_merge;
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.done          = (state == DONE);
  assign bus.rdata         = rdata_q;
  assign bus.error         = error_q;
  assign bus.mem_address   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_read      = (state == RD) || (state == RMW_RD);
  assign bus.mem_write     = (state == WR) || (state == RMW_WR);
  assign bus.mem_writedata = bus.mem_write ? wr_word : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  logic mem_restore;
  logic [31:0] mem0, mem1;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(32)) bus0 ();
  load_store_unit_if #(.ADDR_WIDTH(32)) bus1 ();

  load_store_unit #(.ADDR_WIDTH(32), .MEM_WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  load_store_unit #(.ADDR_WIDTH(32), .MEM_WAIT_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  // Combinational memory with a single populated word at 0x100.
  assign bus0.mem_readdata = (bus0.mem_address == 32'h100) ? mem0 : 32'h0;
  assign bus1.mem_readdata = (bus1.mem_address == 32'h100) ? mem1 : 32'h0;

  always @(posedge clk) begin
    if (mem_restore) begin
      mem0 <= 32'h8899AABB;
      mem1 <= 32'h8899AABB;
    end else begin
      if (bus0.mem_write && bus0.mem_address == 32'h100) mem0 <= bus0.mem_writedata;
      if (bus1.mem_write && bus1.mem_address == 32'h100) mem1 <= bus1.mem_writedata;
    end
  end

  int checks = 0;
  int errors = 0;
  int lat, nrd, nwr, extra, both_total;
  logic got;
  logic [31:0] rd_addr, wr_dat, res_rdata;
  logic res_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] w, input logic [31:0] r);
    if (sel == 0) begin
      bus0.start = s; bus0.op = o; bus0.addr = a; bus0.wdata = w; bus0.rt_old = r;
    end else begin
      bus1.start = s; bus1.op = o; bus1.addr = a; bus1.wdata = w; bus1.rt_old = r;
    end
  endtask

  task automatic sample(input int sel, output logic rd, output logic wr, output logic dn,
                        output logic bz, output logic er, output logic [31:0] ad,
                        output logic [31:0] wd, output logic [31:0] rdt);
    if (sel == 0) begin
      rd = bus0.mem_read; wr = bus0.mem_write; dn = bus0.done; bz = bus0.busy;
      er = bus0.error; ad = bus0.mem_address; wd = bus0.mem_writedata; rdt = bus0.rdata;
    end else begin
      rd = bus1.mem_read; wr = bus1.mem_write; dn = bus1.done; bz = bus1.busy;
      er = bus1.error; ad = bus1.mem_address; wd = bus1.mem_writedata; rdt = bus1.rdata;
    end
  endtask

  // Issue one request at a negedge, then watch each cycle until done (bounded),
  // optionally re-raising start on cycle 'poke', then watch 4 more idle cycles.
  task automatic run(input int sel, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] w, input logic [31:0] r, input int poke);
    logic rd, wr, dn, bz, er;
    logic [31:0] ad, wd, rdt;
    int cyc;
    lat = 0; nrd = 0; nwr = 0; extra = 0; got = 1'b0;
    rd_addr = 32'hFFFFFFFF; wr_dat = 32'hFFFFFFFF; res_rdata = 32'hFFFFFFFF; res_err = 1'bx;
    drive(sel, 1'b1, o, a, w, r);
    cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      sample(sel, rd, wr, dn, bz, er, ad, wd, rdt);
      drive(sel, cyc == poke, o, a, w, r);
      if (rd) begin nrd++; rd_addr = ad; end
      if (wr) begin nwr++; wr_dat = wd; end
      if (rd && wr) both_total++;
      if (dn) begin got = 1'b1; lat = cyc; res_rdata = rdt; res_err = er; end
    end
    check("done_seen", 32'(got), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample(sel, rd, wr, dn, bz, er, ad, wd, rdt);
      drive(sel, 1'b0, o, a, w, r);
      if (rd || wr || dn) extra++;
    end
  endtask

  task automatic restore();
    mem_restore = 1'b1;
    @(negedge clk);
    mem_restore = 1'b0;
  endtask

  initial begin
    logic rd, wr, dn, bz, er;
    logic [31:0] ad, wd, rdt;
    int wr_after;
    both_total = 0;
    reset = 1'b1;
    mem_restore = 1'b1;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);

    // Reset state
    sample(0, rd, wr, dn, bz, er, ad, wd, rdt);
    check("rst_busy", 32'(bz), 0);
    check("rst_done", 32'(dn), 0);
    check("rst_rdata", rdt, 0);
    check("rst_err", 32'(er), 0);
    check("rst_memctl", {30'h0, rd, wr}, 0);
    check("rst_addr", ad, 0);
    reset = 1'b0;
    mem_restore = 1'b0;
    @(negedge clk);

    // LB 0x103
    run(0, 4'b0000, 32'h103, 32'h0, 32'h0, 0);
    check("lb_lat", lat, 2);
    check("lb_rdaddr", rd_addr, 32'h100);
    check("lb_nrd", nrd, 1);
    check("lb_nwr", nwr, 0);
    check("lb_rdata", res_rdata, 32'hFFFFFF88);
    check("lb_err", 32'(res_err), 0);

    run(0, 4'b0011, 32'h102, 32'h0, 32'h0, 0);
    check("lhu_rdata", res_rdata, 32'h00008899);
    run(0, 4'b0010, 32'h100, 32'h0, 32'h0, 0);
    check("lh_rdata", res_rdata, 32'hFFFFAABB);
    run(0, 4'b0001, 32'h100, 32'h0, 32'h0, 0);
    check("lbu_rdata", res_rdata, 32'h000000BB);

    run(0, 4'b0101, 32'h101, 32'h0, 32'h11223344, 0);
    check("lwl1_rdata", res_rdata, 32'hAABB3344);
    run(0, 4'b0110, 32'h101, 32'h0, 32'h11223344, 0);
    check("lwr1_rdata", res_rdata, 32'h118899AA);
    run(0, 4'b0101, 32'h103, 32'h0, 32'h11223344, 0);
    check("lwl3_rdata", res_rdata, 32'h8899AABB);
    run(0, 4'b0110, 32'h100, 32'h0, 32'h11223344, 0);
    check("lwr0_rdata", res_rdata, 32'h8899AABB);

    // Misaligned LW 0x102
    run(0, 4'b0100, 32'h102, 32'h0, 32'h0, 0);
    check("mis_rdata", res_rdata, 32'h8899AABB);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_lat", lat, 1);
    check("mis_err", 32'(res_err), 1);
    check("mis_nrd", nrd, 0);
`else
    check("mis_lat", lat, 2);
    check("mis_err", 32'(res_err), 0);
    check("mis_nrd", nrd, 1);
`endif

    // Reserved op
    run(0, 4'b0111, 32'h100, 32'h0, 32'h0, 0);
    check("rsv_lat", lat, 1);
    check("rsv_err", 32'(res_err), 1);
    check("rsv_acc", nrd + nwr, 0);
    check("rsv_rdata", res_rdata, 32'h8899AABB);

    // start raised during the DONE cycle is ignored
    run(0, 4'b0100, 32'h100, 32'h0, 32'h0, 2);
    check("lw_lat", lat, 2);
    check("lw_done_poke_extra", extra, 0);

    // SB 0x101
    run(0, 4'b1000, 32'h101, 32'h12345655, 32'h0, 0);
    check("sb_lat", lat, 3);
    check("sb_nrd", nrd, 1);
    check("sb_nwr", nwr, 1);
    check("sb_wdat", wr_dat, 32'h889955BB);
    check("sb_mem", mem0, 32'h889955BB);
    restore();
    run(0, 4'b1001, 32'h102, 32'h0000CAFE, 32'h0, 0);
    check("sh_lat", lat, 3);
    check("sh_wdat", wr_dat, 32'hCAFEAABB);
    restore();
    run(0, 4'b1010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    check("sw_lat", lat, 2);
    check("sw_nrd", nrd, 0);
    check("sw_wdat", wr_dat, 32'hDEADBEEF);
    restore();

    // Reset during RMW_RD of an SB
    drive(0, 1'b1, 4'b1000, 32'h101, 32'h000000EE, 32'h0);
    @(negedge clk);
    sample(0, rd, wr, dn, bz, er, ad, wd, rdt);
    check("rmw_rd_active", 32'(rd), 1);
    drive(0, 1'b0, 4'b1000, 32'h101, 32'h000000EE, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    sample(0, rd, wr, dn, bz, er, ad, wd, rdt);
    reset = 1'b0;
    check("abort_busy_done", {30'h0, bz, dn}, 0);
    check("abort_rdata", rdt, 0);
    check("abort_memctl", {30'h0, rd, wr}, 0);
    check("abort_addr_wd", ad | wd, 0);
    wr_after = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus0.mem_write) wr_after++;
    end
    check("abort_no_write", wr_after, 0);
    check("abort_mem", mem0, 32'h8899AABB);

    // MEM_WAIT_CYCLES=2, start while busy ignored
    run(1, 4'b0100, 32'h100, 32'h0, 32'h0, 2);
    check("w2_lw_lat", lat, 4);
    check("w2_lw_nrd", nrd, 3);
    check("w2_lw_extra", extra, 0);
    check("w2_lw_rdata", res_rdata, 32'h8899AABB);
    run(1, 4'b1000, 32'h100, 32'h00000077, 32'h0, 0);
    check("w2_sb_lat", lat, 7);
    check("w2_sb_acc", {nrd[15:0], nwr[15:0]}, {16'd3, 16'd3});
    check("w2_sb_wdat", wr_dat, 32'h8899AA77);

    check("rd_wr_overlap", both_total, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
